// File: rtl/quad_pkg.sv
// quad_pkg: FSM state encodings shared by the quadrature decoder and sampler,
// plus a sign-extension helper for widening wrapped count deltas.
package quad_pkg;

  typedef logic [1:0] state_t;

  localparam state_t PRIME = 2'd0;
  localparam state_t IDLE  = 2'd1;
  localparam state_t RUN   = 2'd2;

  localparam int unsigned SEXT_MAX_W = 64;

  // Sign-extends the low from_w bits of value to the full SEXT_MAX_W width.
  // Callers truncate the result to their own target width.
  function automatic logic signed [SEXT_MAX_W-1:0] sign_extend(
    input logic [SEXT_MAX_W-1:0] value,
    input int unsigned           from_w
  );
    logic signed [SEXT_MAX_W-1:0] shifted;
    shifted = signed'(value << (SEXT_MAX_W - from_w));
    return shifted >>> (SEXT_MAX_W - from_w);
  endfunction

endpackage

// File: rtl/quad_wrap_delta.sv
// quad_wrap_delta: combinational signed step between two samples of a
// free-running WIDTH-bit counter, valid across the wrap point.
module quad_wrap_delta
  import quad_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]        count_i,
  input  logic [WIDTH-1:0]        prev_count_i,
  output logic signed [WIDTH-1:0] delta_o
);

  // Modular subtraction reinterpreted as signed yields the shortest step, so a
  // roll from 0xFF to 0x00 reads as +1 rather than -255.
  assign delta_o = signed'(count_i - prev_count_i);

endmodule

// File: rtl/quadrature_sampler.sv
// quadrature_sampler: extends the decoder's wrapping count into a signed position and
// offers periodic velocity samples over valid/ready. Define QUAD_SAMPLER_INDEX_EN for index homing.
module quadrature_sampler
  import quad_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int POS_WIDTH = 32,
  parameter int VEL_WIDTH = 16,
  parameter int PERIOD    = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     count,
  input  logic                 enable,
  output logic [POS_WIDTH-1:0] position,
  output logic [VEL_WIDTH-1:0] vel,
  output logic                 vel_valid,
  input  logic                 vel_ready,
  output logic                 overrun,
  input  logic                 overrun_clr
`ifdef QUAD_SAMPLER_INDEX_EN
  ,
  input  logic                 index,
  output logic                 homed
`endif
);

  localparam int TW = $clog2(PERIOD);

  if ((POS_WIDTH <= WIDTH) || (VEL_WIDTH < WIDTH) || (PERIOD < 2)) begin : g_bad_params
    $error("quadrature_sampler: illegal parameter combination");
  end

  state_t                       state_q, state_d;
  logic [TW-1:0]                timer_q, timer_d;
  logic [WIDTH-1:0]             prev_count_q;
  logic signed [POS_WIDTH-1:0]  pos_q, pos_d, pos_acc, base_q, base_d, step_ext;
  logic signed [WIDTH-1:0]      delta;
  logic [VEL_WIDTH-1:0]         vel_q, vel_d;
  logic                         valid_q, valid_d;
  logic                         overrun_q, overrun_d;
  logic                         accumulate, enter_run, tick, index_edge;

  quad_wrap_delta #(
    .WIDTH(WIDTH)
  ) u_wrap_delta (
    .count_i     (count),
    .prev_count_i(prev_count_q),
    .delta_o     (delta)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= PRIME;
    else     state_q <= state_d;
  end

  // NOTE: every variable assigned in a combinational block gets a default first,
  // otherwise paths that skip the assignment infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIME:   state_d = enable ? RUN : IDLE;
      IDLE:    if (enable)  state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = PRIME;
    endcase
  end

  always_comb begin
    accumulate = (state_q != PRIME);
    enter_run  = (state_q != RUN) && (state_d == RUN);
    tick       = (state_q == RUN) && enable && (timer_q == TW'(PERIOD - 1));
    timer_d    = '0;
    if ((state_q == RUN) && enable && !tick) timer_d = timer_q + TW'(1);
  end

`ifdef QUAD_SAMPLER_INDEX_EN
  logic index_q, homed_q;

  assign index_edge = index && !index_q;
  assign homed      = homed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q <= 1'b0;
      homed_q <= 1'b0;
    end else begin
      index_q <= index;
      if (index_edge) homed_q <= 1'b1;
    end
  end
`else
  assign index_edge = 1'b0;
`endif

  // A tick measures from the pre-index position; base then follows whatever
  // position actually gets stored so the next sample starts from it.
  always_comb begin
    step_ext  = POS_WIDTH'(sign_extend(SEXT_MAX_W'(delta), WIDTH));
    pos_acc   = accumulate ? (pos_q + step_ext) : pos_q;
    pos_d     = index_edge ? '0 : pos_acc;
    base_d    = (enter_run || tick || index_edge) ? pos_d : base_q;
    vel_d     = vel_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (tick) begin
      vel_d   = VEL_WIDTH'(pos_acc - base_q);
      valid_d = 1'b1;
    end else if (valid_q && vel_ready) begin
      valid_d = 1'b0;
    end
    if (tick && valid_q && !vel_ready) overrun_d = 1'b1;
    else if (overrun_clr)              overrun_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q      <= '0;
      prev_count_q <= '0;
      pos_q        <= '0;
      base_q       <= '0;
      vel_q        <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      prev_count_q <= count;
      pos_q        <= pos_d;
      base_q       <= base_d;
      vel_q        <= vel_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign position  = pos_q;
  assign vel       = vel_q;
  assign vel_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_quadrature_sampler.sv
// tb_quadrature_sampler: randomized and directed checks of quadrature_sampler against a
// queue-based reference model (WIDTH=8, POS_WIDTH=16, VEL_WIDTH=8, PERIOD=4).
module tb_quadrature_sampler;

  localparam int WIDTH     = 8;
  localparam int POS_WIDTH = 16;
  localparam int VEL_WIDTH = 8;
  localparam int PERIOD    = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [WIDTH-1:0]     count = '0;
  logic                 enable = 1'b0;
  logic                 vel_ready = 1'b0;
  logic                 overrun_clr = 1'b0;
  logic [POS_WIDTH-1:0] position;
  logic [VEL_WIDTH-1:0] vel;
  logic                 vel_valid;
  logic                 overrun;
`ifdef QUAD_SAMPLER_INDEX_EN
  logic                 index = 1'b0;
  logic                 homed;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state: true position, run flag, and the positions seen
  // since the current sampling window opened (front = window base).
  bit             m_primed, m_run, m_valid, m_over, m_homed, m_idx_prev;
  logic [7:0]     m_prev, m_vel;
  logic [15:0]    m_pos;
  logic [15:0]    m_win[$];

  quadrature_sampler #(
    .WIDTH    (WIDTH),
    .POS_WIDTH(POS_WIDTH),
    .VEL_WIDTH(VEL_WIDTH),
    .PERIOD   (PERIOD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .count      (count),
    .enable     (enable),
    .position   (position),
    .vel        (vel),
    .vel_valid  (vel_valid),
    .vel_ready  (vel_ready),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
`ifdef QUAD_SAMPLER_INDEX_EN
    ,
    .index      (index),
    .homed      (homed)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, want finished)");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_primed = 0; m_run = 0; m_valid = 0; m_over = 0; m_homed = 0; m_idx_prev = 0;
    m_prev = '0; m_vel = '0; m_pos = '0;
    m_win.delete();
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_step();
    int          d;
    logic [15:0] acc, nxt;
    logic [7:0]  new_vel;
    bit          idx, idx_edge, tick;
`ifdef QUAD_SAMPLER_INDEX_EN
    idx = index;
`else
    idx = 1'b0;
`endif
    idx_edge = idx && !m_idx_prev;
    tick     = 0;
    new_vel  = m_vel;
    if (!m_primed) begin
      acc      = m_pos;
      m_primed = 1;
    end else begin
      d = int'(8'(count - m_prev));
      if (d >= 128) d -= 256;
      acc = 16'(int'(m_pos) + d);
    end
    nxt = idx_edge ? 16'h0000 : acc;
    if (m_run && enable) begin
      m_win.push_back(acc);
      if (m_win.size() == PERIOD + 1) begin
        tick    = 1;
        new_vel = 8'(m_win[m_win.size()-1] - m_win[0]);
        m_win   = {nxt};
      end else if (idx_edge) begin
        m_win[0] = 16'h0000;
      end
    end else if (enable) begin
      m_win = {nxt};
    end
    m_run = enable;
    if (tick && m_valid && !vel_ready) m_over = 1;
    else if (overrun_clr)              m_over = 0;
    if (tick)                       m_valid = 1;
    else if (m_valid && vel_ready)  m_valid = 0;
    m_vel      = new_vel;
    m_prev     = count;
    m_pos      = nxt;
    m_idx_prev = idx;
    if (idx_edge) m_homed = 1;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic [7:0] c);
    @(negedge clk);
    count = c; enable = 0; vel_ready = 0; overrun_clr = 0;
`ifdef QUAD_SAMPLER_INDEX_EN
    index = 0;
`endif
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({position, vel, vel_valid, overrun} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs: got pos=%h vel=%h valid=%b ovr=%b, want all zero",
               position, vel, vel_valid, overrun);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(8'h37);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({position, vel_valid} !== {16'h0000, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got pos=%h valid=%b, want pos=0000 valid=0",
                 i, position, vel_valid);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] seq [5];
    seq = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
    apply_reset(8'hFE);
    foreach (seq[i]) begin
      count = seq[i];
      step();
      checks++;
      if (position !== m_pos) begin
        errors++;
        $display("FAIL wrap_track step %0d: got pos=%h, want %h", i, position, m_pos);
      end
    end
    checks++;
    if (position !== 16'h0004) begin
      errors++;
      $display("FAIL wrap_up: got pos=%h, want 0004", position);
    end
    count = 8'hFD;
    step();
    checks++;
    if (position !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_down: got pos=%h, want ffff", position);
    end
  endtask

  task automatic test_velocity();
    int pulses = 0;
    int first  = -1;
    apply_reset(8'h00);
    enable = 1; vel_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      count = count + 8'd1;
      step();
      checks++;
      if ({position, vel, vel_valid, overrun} !== {m_pos, m_vel, m_valid, m_over}) begin
        errors++;
        $display("FAIL velocity_model cycle %0d: got %h/%h/%b/%b, want %h/%h/%b/%b", i,
                 position, vel, vel_valid, overrun, m_pos, m_vel, m_valid, m_over);
      end
      if (vel_valid) begin
        pulses++;
        if (first < 0) first = i;
        checks++;
        if (vel !== 8'd4) begin
          errors++;
          $display("FAIL velocity_value cycle %0d: got vel=%0d, want 4", i, vel);
        end
      end
    end
    checks++;
    if ({first, pulses} !== {32'd5, 32'd3}) begin
      errors++;
      $display("FAIL velocity_timing: got first=%0d pulses=%0d, want first=5 pulses=3",
               first, pulses);
    end
  endtask

  task automatic test_overrun();
    apply_reset(8'h00);
    enable = 1; vel_ready = 0;
    for (int i = 1; i <= 9; i++) begin
      count = count + 8'd1;
      step();
      checks++;
      if ({position, vel, vel_valid, overrun} !== {m_pos, m_vel, m_valid, m_over}) begin
        errors++;
        $display("FAIL overrun_model cycle %0d: got %h/%h/%b/%b, want %h/%h/%b/%b", i,
                 position, vel, vel_valid, overrun, m_pos, m_vel, m_valid, m_over);
      end
    end
    checks++;
    if ({vel, vel_valid, overrun} !== {8'd4, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL overrun_set: got vel=%0d valid=%b ovr=%b, want vel=4 valid=1 ovr=1",
               vel, vel_valid, overrun);
    end
    overrun_clr = 1;
    count = count + 8'd1;
    step();
    overrun_clr = 0;
    checks++;
    if ({vel_valid, overrun} !== 2'b10) begin
      errors++;
      $display("FAIL overrun_clear: got valid=%b ovr=%b, want valid=1 ovr=0", vel_valid, overrun);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) count = 8'($urandom);
      else                           count = count + 8'($urandom_range(0, 20) - 10);
      enable      = ($urandom_range(0, 7) != 0);
      vel_ready   = $urandom_range(0, 1) == 1;
      overrun_clr = ($urandom_range(0, 9) == 0);
`ifdef QUAD_SAMPLER_INDEX_EN
      index = ($urandom_range(0, 15) == 0);
`endif
      step();
      checks++;
      if ({position, vel, vel_valid, overrun} !== {m_pos, m_vel, m_valid, m_over}) begin
        errors++;
        $display("FAIL random_model cycle %0d: got %h/%h/%b/%b, want %h/%h/%b/%b", i,
                 position, vel, vel_valid, overrun, m_pos, m_vel, m_valid, m_over);
      end
    end
    overrun_clr = 0;
  endtask

  task automatic test_reset_mid();
    apply_reset(8'h10);
    enable = 1; vel_ready = 0;
    for (int i = 0; i < 7; i++) begin
      count = count + 8'd3;
      step();
    end
    checks++;
    if (vel_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pending: got valid=%b, want 1", vel_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({position, vel, vel_valid, overrun} !== 26'd0) begin
      errors++;
      $display("FAIL reset_mid_async: got pos=%h vel=%h valid=%b ovr=%b, want all zero",
               position, vel, vel_valid, overrun);
    end
    @(negedge clk);
    count = 8'hA5;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({position, vel_valid} !== {16'h0000, 1'b0}) begin
        errors++;
        $display("FAIL reset_mid_prime cycle %0d: got pos=%h valid=%b, want 0000/0",
                 i, position, vel_valid);
      end
    end
    enable = 0;
  endtask

`ifdef QUAD_SAMPLER_INDEX_EN
  task automatic test_index();
    apply_reset(8'h00);
    checks++;
    if (homed !== 1'b0) begin
      errors++;
      $display("FAIL index_reset: got homed=%b, want 0", homed);
    end
    step();
    count = 8'd10;
    step();
    checks++;
    if (position !== 16'd10) begin
      errors++;
      $display("FAIL index_pre: got pos=%h, want 000a", position);
    end
    index = 1; count = 8'd11;
    step();
    checks++;
    if ({position, homed} !== {16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL index_first: got pos=%h homed=%b, want 0000/1", position, homed);
    end
    count = 8'd14;
    step();
    index = 0;
    step();
    checks++;
    if (position !== 16'd3) begin
      errors++;
      $display("FAIL index_level: got pos=%h, want 0003", position);
    end
    index = 1; count = 8'd20;
    step();
    index = 0;
    checks++;
    if ({position, homed} !== {16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL index_second: got pos=%h homed=%b, want 0000/1", position, homed);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_wrap();
    test_velocity();
    test_overrun();
    test_random();
    test_reset_mid();
`ifdef QUAD_SAMPLER_INDEX_EN
    test_index();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/quadrature_sampler.md
Name: quadrature_sampler

Overview:
Periodic sampling controller for the quadrature decoder's free-running WIDTH-bit count. Each cycle it extends the wrapping count into a wide signed position. Every PERIOD cycles it snapshots a signed velocity (counts per period) and offers it to a consumer over a valid/ready handshake. It sits between the decoder and the control/telemetry logic, so downstream logic never handles counter wrap.

Parameters:
WIDTH, 8, width of decoder count input; must match decoder width.
POS_WIDTH, 32, width of extended signed position; must be > WIDTH.
VEL_WIDTH, 16, width of signed velocity sample; must be >= WIDTH.
PERIOD, 1000, clk cycles between velocity samples; must be >= 2.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
count  in  WIDTH  decoder count, unsigned, wraps modulo 2^WIDTH.
enable  in  1  high = sampling timer runs; position tracking is unaffected.
position  out  POS_WIDTH  signed extended position.
vel  out  VEL_WIDTH  signed velocity sample, stable while vel_valid.
vel_valid  out  1  sample available.
vel_ready  in  1  consumer accepts sample when vel_valid && vel_ready.
overrun  out  1  sticky: a sample was overwritten unconsumed.
overrun_clr  in  1  synchronous clear of overrun.

Behaviour:
- Reset (async, active-high): position=0, vel=0, vel_valid=0, overrun=0, timer=0, prev_count=0, state=PRIME.
- Step delta: d = (count - prev_count) mod 2^WIDTH, interpreted as signed WIDTH-bit (range -2^(WIDTH-1)..2^(WIDTH-1)-1), then sign-extended. Each cycle: prev_count<=count; position<=position+d. Position wraps modulo 2^POS_WIDTH with no saturation.
- FSM states:
  - PRIME: one cycle after reset. prev_count<=count, no accumulation. Next state is IDLE, or RUN if enable.
  - IDLE: timer held at 0, no new samples; any pending vel_valid remains until accepted. RUN when enable=1.
  - RUN: timer increments each cycle. At timer==PERIOD-1: timer<=0, tick. enable=0 returns to IDLE and clears the timer.
- Entering RUN from PRIME or IDLE latches base<=position (next-value, including that cycle's delta).
- Tick: vel<=position_next - base, truncated to VEL_WIDTH (two's complement); base<=position_next; vel_valid<=1. vel_valid rises the cycle after the tick-edge (1-cycle latency). First sample arrives PERIOD cycles after entering RUN.
- Handshake: vel_valid&&vel_ready clears vel_valid next cycle. vel is held constant while valid and not accepted.
- Tick while vel_valid && !vel_ready: vel is replaced by the new sample, vel_valid stays 1, overrun<=1.
- Tick in the same cycle as acceptance: the new sample loads, vel_valid stays 1, no overrun.
- overrun_clr in the same cycle as a new overrun: the set wins.
- Reset mid-operation discards any pending sample and returns to PRIME. No spurious delta is produced from the reset-time count.

Optional Feature:
QUAD_SAMPLER_INDEX_EN.
- Defined: adds input index (1 bit, synchronous to clk) and output homed (1 bit, reset 0).
- On the first cycle index is high after being low (registered edge detect, previous index reset 0): position<=0, discarding that cycle's delta; base<=0; homed<=1 and stays set until rst.
- A tick in the same cycle computes vel from pre-index position, then base<=0.
- Undefined: ports index and homed are absent; position is never zeroed except by rst.

Decomposition:
- Package quad_pkg: FSM state encodings (PRIME, IDLE, RUN) as localparams, plus a signed-extend helper function for WIDTH->POS_WIDTH. The decoder reuses these constants.
- One sub-module, quad_wrap_delta: combinational count, prev_count -> signed WIDTH-bit delta, parameterised WIDTH.
- Timer and FSM stay in quadrature_sampler.

Test Plan:
Bench settings: WIDTH=8, POS_WIDTH=16, VEL_WIDTH=8, PERIOD=4.
1. rst with count=0x37 held, release -> position stays 0 for all cycles while count is constant; vel_valid=0.
2. count steps 0xFE,0xFF,0x00,0x01,0x02 one per cycle -> position=+4 (0x0004). Then steps 0x02->0xFD -> position=-1 (0xFFFF).
3. enable=1, vel_ready=1, count +1 per cycle -> after PERIOD cycles a vel_valid pulse with vel=4, then repeats every 4 cycles; overrun=0.
4. enable=1, vel_ready=0, count +1 per cycle for 8 cycles -> first vel=4, then vel=4 again with overrun=1. overrun_clr pulse -> overrun=0, vel_valid still 1.
5. Assert rst mid-RUN with vel_valid=1 -> all outputs 0 immediately (async). After release, PRIME absorbs the current count with no delta.
6. (QUAD_SAMPLER_INDEX_EN) position=+10, index 0->1 -> next cycle position=0, homed=1. A second index rising edge re-zeroes position; homed remains 1.
